// File: rtl/jtag_dr_scan_path.sv
// jtag_dr_scan_path
//   Data-register scan path for the JTAG test port. It holds the bypass,
//   IDCODE, boundary-scan (BSR) and user data registers. The current
//   instruction selects one register, and that register is shifted between
//   tdi and tdo under the TAP capture/shift/update strobes. Boundary cells
//   have update latches, and an EXTEST mux lets scan drive the pads.
//
// Parameters
//   IR_WIDTH      instruction width (>= 3)
//   BSR_LENGTH    number of boundary-scan cells (>= 1)
//   USER_WIDTH    user data register length (>= 1)
//   IDCODE_VALUE  device ID; bit 0 is always captured as 1
//
// Ports
//   clk            TCK; all state changes on the rising edge
//   reset          asynchronous, active-low; clears all state
//   capture        Capture-DR strobe (one cycle)
//   shift          Shift-DR level
//   update         Update-DR strobe (one cycle)
//   tdi            serial in
//   instruction    current IR contents
//   pins_in        values sampled from the pads
//   core_out       functional core values destined for the pads
//   pins_out       values driven to the pads
//   user_data      user register update latch
//   user_strobe    one-cycle pulse after a user-register update
//   extest_active  high while EXTEST is decoded
//   tdo            serial out; bit 0 of the selected register

module jtag_dr_scan_path #(
  parameter int unsigned IR_WIDTH     = 4,
  parameter int unsigned BSR_LENGTH   = 8,
  parameter int unsigned USER_WIDTH   = 16,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture,
  input  logic                  shift,
  input  logic                  update,
  input  logic                  tdi,
  input  logic [IR_WIDTH-1:0]   instruction,
  input  logic [BSR_LENGTH-1:0] pins_in,
  input  logic [BSR_LENGTH-1:0] core_out,
  output logic [BSR_LENGTH-1:0] pins_out,
  output logic [USER_WIDTH-1:0] user_data,
  output logic                  user_strobe,
  output logic                  extest_active,
  output logic                  tdo
);

  if (IR_WIDTH < 3) begin : g_bad_ir
    $error("jtag_dr_scan_path: IR_WIDTH must be at least 3");
  end
  if (BSR_LENGTH < 1) begin : g_bad_bsr
    $error("jtag_dr_scan_path: BSR_LENGTH must be at least 1");
  end
  if (USER_WIDTH < 1) begin : g_bad_user
    $error("jtag_dr_scan_path: USER_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_BSR,
    SEL_IDCODE,
    SEL_USER
  } dr_sel_e;

  dr_sel_e               sel;
  logic                  do_capture;
  logic                  do_shift;
  logic                  do_update;

  logic                  bypass_reg;
  logic [31:0]           idcode_reg;
  logic [BSR_LENGTH-1:0] bsr_shift;
  logic [BSR_LENGTH-1:0] bsr_latch;
  logic [USER_WIDTH-1:0] user_shift;

  // Instruction decode. All-ones and every unassigned code fall through to
  // BYPASS.
  always_comb begin
    sel           = SEL_BYPASS;
    extest_active = 1'b0;
    if (instruction == '1) begin
      sel = SEL_BYPASS;
    end else if (instruction == IR_WIDTH'(0)) begin
      sel           = SEL_BSR;
      extest_active = 1'b1;
    end else if (instruction == IR_WIDTH'(1)) begin
      sel = SEL_BSR;
    end else if (instruction == IR_WIDTH'(2)) begin
      sel = SEL_IDCODE;
    end else if (instruction == IR_WIDTH'(3)) begin
      sel = SEL_USER;
    end
  end

  // Only one action per cycle: capture beats shift, and shift beats update.
  always_comb begin
    do_capture = capture;
    do_shift   = shift & ~capture;
    do_update  = update & ~capture & ~shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bypass_reg <= 1'b0;
    end else if (sel == SEL_BYPASS) begin
      if (do_capture) begin
        bypass_reg <= 1'b0;
      end else if (do_shift) begin
        bypass_reg <= tdi;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idcode_reg <= '0;
    end else if (sel == SEL_IDCODE) begin
      if (do_capture) begin
        idcode_reg <= IDCODE_VALUE | 32'd1;
      end else if (do_shift) begin
        idcode_reg <= {tdi, idcode_reg[31:1]};
      end
    end
  end

  // The BSR holds a shift stage and a separate update latch. The latch keeps
  // its value while the shift stage is scanned, so SAMPLE/PRELOAD can stage
  // pad values before EXTEST starts driving them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bsr_shift <= '0;
      bsr_latch <= '0;
    end else if (sel == SEL_BSR) begin
      if (do_capture) begin
        bsr_shift <= pins_in;
      end else if (do_shift) begin
        if (BSR_LENGTH > 1) begin
          bsr_shift <= {tdi, bsr_shift[BSR_LENGTH-1:1]};
        end else begin
          bsr_shift <= tdi;
        end
      end else if (do_update) begin
        bsr_latch <= bsr_shift;
      end
    end
  end

  // User register. Capture reads back the update latch. The strobe is
  // registered, so it is high in the cycle after the latch is written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      user_shift  <= '0;
      user_data   <= '0;
      user_strobe <= 1'b0;
    end else begin
      user_strobe <= (sel == SEL_USER) && do_update;
      if (sel == SEL_USER) begin
        if (do_capture) begin
          user_shift <= user_data;
        end else if (do_shift) begin
          if (USER_WIDTH > 1) begin
            user_shift <= {tdi, user_shift[USER_WIDTH-1:1]};
          end else begin
            user_shift <= tdi;
          end
        end else if (do_update) begin
          user_data <= user_shift;
        end
      end
    end
  end

  always_comb begin
    tdo = bypass_reg;
    case (sel)
      SEL_BSR:    tdo = bsr_shift[0];
      SEL_IDCODE: tdo = idcode_reg[0];
      SEL_USER:   tdo = user_shift[0];
      default:    tdo = bypass_reg;
    endcase
  end

  always_comb begin
    pins_out = extest_active ? bsr_latch : core_out;
  end

endmodule

// File: tb/tb_jtag_dr_scan_path.sv
// Directed testbench for jtag_dr_scan_path (default parameters).
// Inputs are driven and outputs are sampled on the falling edge of clk.
module tb_jtag_dr_scan_path;

  logic        clk = 1'b0;
  logic        reset;
  logic        capture, shift, update, tdi;
  logic [3:0]  instruction;
  logic [7:0]  pins_in, core_out, pins_out;
  logic [15:0] user_data;
  logic        user_strobe, extest_active, tdo;

  int total = 0;
  int bad   = 0;

  jtag_dr_scan_path #(
    .IR_WIDTH    (4),
    .BSR_LENGTH  (8),
    .USER_WIDTH  (16),
    .IDCODE_VALUE(32'h1000_0001)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .capture      (capture),
    .shift        (shift),
    .update       (update),
    .tdi          (tdi),
    .instruction  (instruction),
    .pins_in      (pins_in),
    .core_out     (core_out),
    .pins_out     (pins_out),
    .user_data    (user_data),
    .user_strobe  (user_strobe),
    .extest_active(extest_active),
    .tdo          (tdo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle(); instruction = 4'd0;
    pins_in = 8'hFF; core_out = 8'h77;
    #2;
    total++; if (tdo !== 1'b0) begin bad++; $display("FAIL reset_tdo got=%b exp=0", tdo); end
    total++; if (user_data !== 16'h0) begin bad++; $display("FAIL reset_user_data got=%h exp=0000", user_data); end
    total++; if (user_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", user_strobe); end
    total++; if (pins_out !== 8'h00) begin bad++; $display("FAIL reset_pins_extest got=%h exp=00", pins_out); end
    total++; if (extest_active !== 1'b1) begin bad++; $display("FAIL reset_extest got=%b exp=1", extest_active); end
    instruction = 4'd15; #1;
    total++; if (pins_out !== 8'h77) begin bad++; $display("FAIL reset_pins_bypass got=%h exp=77", pins_out); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_idcode();
    logic [31:0] id;
    id = 32'h1000_0001;
    instruction = 4'd2; capture = 1'b1;
    tick();
    capture = 1'b0; shift = 1'b1;
    for (int i = 0; i < 32; i++) begin
      total++;
      if (tdo !== id[i]) begin bad++; $display("FAIL idcode_bit%0d got=%b exp=%b", i, tdo, id[i]); end
      tick();
    end
    idle();
  endtask

  task automatic test_bypass(input logic [3:0] code);
    logic [3:0] pat;
    logic [3:0] exp;
    pat = 4'b1101;  // applied bit 0 first: 1,0,1,1
    exp = 4'b1010;  // expected bit 0 first: 0,1,0,1
    instruction = code; capture = 1'b1;
    tick();
    capture = 1'b0; shift = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tdi = pat[i];
      total++;
      if (tdo !== exp[i]) begin bad++; $display("FAIL bypass%0d_bit%0d got=%b exp=%b", code, i, tdo, exp[i]); end
      tick();
    end
    total++; if (tdo !== 1'b1) begin bad++; $display("FAIL bypass%0d_last got=%b exp=1", code, tdo); end
    idle();
  endtask

  task automatic test_sample_extest();
    logic [7:0] cap;
    logic [7:0] din;
    cap = 8'hA5; din = 8'h3C;
    instruction = 4'd1; pins_in = cap; core_out = 8'h5A; capture = 1'b1;
    tick();
    capture = 1'b0; shift = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tdi = din[i];
      total++;
      if (tdo !== cap[i]) begin bad++; $display("FAIL sample_bit%0d got=%b exp=%b", i, tdo, cap[i]); end
      tick();
    end
    shift = 1'b0; update = 1'b1;
    tick();
    update = 1'b0; #1;
    total++; if (pins_out !== 8'h5A) begin bad++; $display("FAIL preload_pins got=%h exp=5a", pins_out); end
    total++; if (extest_active !== 1'b0) begin bad++; $display("FAIL preload_extest got=%b exp=0", extest_active); end
    instruction = 4'd0; #1;
    total++; if (pins_out !== 8'h3C) begin bad++; $display("FAIL extest_pins got=%h exp=3c", pins_out); end
    total++; if (extest_active !== 1'b1) begin bad++; $display("FAIL extest_active got=%b exp=1", extest_active); end
    core_out = 8'hC3; #1;
    total++; if (pins_out !== 8'h3C) begin bad++; $display("FAIL extest_hold got=%h exp=3c", pins_out); end
    tick();
    idle();
  endtask

  task automatic test_user();
    logic [15:0] val;
    val = 16'hBEEF;
    instruction = 4'd3; shift = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tdi = val[i];
      tick();
    end
    shift = 1'b0; update = 1'b1; #1;
    total++; if (user_strobe !== 1'b0) begin bad++; $display("FAIL user_strobe_early got=%b exp=0", user_strobe); end
    tick();
    update = 1'b0; #1;
    total++; if (user_data !== 16'hBEEF) begin bad++; $display("FAIL user_data got=%h exp=beef", user_data); end
    total++; if (user_strobe !== 1'b1) begin bad++; $display("FAIL user_strobe_pulse got=%b exp=1", user_strobe); end
    tick();
    total++; if (user_strobe !== 1'b0) begin bad++; $display("FAIL user_strobe_len got=%b exp=0", user_strobe); end
    capture = 1'b1;
    tick();
    capture = 1'b0; shift = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (tdo !== val[i]) begin bad++; $display("FAIL user_readback_bit%0d got=%b exp=%b", i, tdo, val[i]); end
      tick();
    end
    idle();
  endtask

  task automatic test_priority();
    logic [7:0] cap;
    cap = 8'h0F;
    // BSR update latch still holds 8'h3C; EXTEST shows it on the pads.
    instruction = 4'd0; pins_in = cap;
    capture = 1'b1; shift = 1'b1; update = 1'b1; tdi = 1'b1;
    tick();
    capture = 1'b0; update = 1'b0; #1;
    total++; if (pins_out !== 8'h3C) begin bad++; $display("FAIL prio_no_update got=%h exp=3c", pins_out); end
    tdi = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (tdo !== cap[i]) begin bad++; $display("FAIL prio_capture_bit%0d got=%b exp=%b", i, tdo, cap[i]); end
      tick();
    end
    // shift beats update: the latch keeps 8'h3C
    shift = 1'b1; update = 1'b1;
    tick();
    idle(); #1;
    total++; if (pins_out !== 8'h3C) begin bad++; $display("FAIL prio_shift_over_update got=%h exp=3c", pins_out); end
  endtask

  task automatic test_reset_mid_shift();
    instruction = 4'd3; core_out = 8'h96; shift = 1'b1; tdi = 1'b1;
    tick();
    tick();
    #1;
    reset = 1'b0; #1;
    total++; if (user_data !== 16'h0) begin bad++; $display("FAIL rst_user_data got=%h exp=0000", user_data); end
    total++; if (tdo !== 1'b0) begin bad++; $display("FAIL rst_tdo got=%b exp=0", tdo); end
    total++; if (pins_out !== 8'h96) begin bad++; $display("FAIL rst_pins got=%h exp=96", pins_out); end
    shift = 1'b0; update = 1'b1;
    tick();
    total++; if (user_strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe got=%b exp=0", user_strobe); end
    update = 1'b0; reset = 1'b1;
    tick();
    total++; if (user_strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe_after got=%b exp=0", user_strobe); end
    instruction = 4'd0; #1;
    total++; if (pins_out !== 8'h00) begin bad++; $display("FAIL rst_bsr_latch got=%h exp=00", pins_out); end
    instruction = 4'd3; capture = 1'b1;
    tick();
    capture = 1'b0; shift = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (tdo !== 1'b0) begin bad++; $display("FAIL rst_readback_bit%0d got=%b exp=0", i, tdo); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_bypass(4'd15);
    test_bypass(4'd7);
    test_sample_extest();
    test_user();
    test_priority();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
